// File: rtl/core_id_operand_fetch.sv
// core_id_operand_fetch
//   Operand-fetch stage of the ID pipe. Takes decoded instructions, drives the
//   two synchronous (1-cycle latency) register-file read ports, and resolves
//   RAW hazards by forwarding from EX/MEM/WB or stalling on a load-use hazard.
//   One stage register sits between the input and output handshakes.
//
// Handshake: a transfer happens on a rising edge where valid && ready are both
//   high. A producer that has raised valid holds it and its data until that
//   edge. ready may depend on valid. Here, out_valid deasserts while an operand
//   is still unknown. in_ready is high when the stage is empty or is firing.
//
// Ports
//   clk, rst_n                  clock, asynchronous active-low reset
//   in_valid/in_ready           upstream handshake
//   in_pc, in_rs1, in_rs2       instruction PC and source register indices
//   in_rs1_used, in_rs2_used    operand is consumed (gates hazard detection)
//   in_payload                  opaque decoded control, passed through
//   rf_read_{0,1}_addr/_data    register-file read ports (data 1 cycle later)
//   wb_en/wb_addr/wb_data       snoop of the register-file write port
//   fwd_ex_*                    EX result; _ready=0 means not yet known (load)
//   fwd_mem_*                   MEM result, always known
//   flush                       kill stage contents and same-cycle input
//   out_valid/out_ready         downstream (EX) handshake
//   out_pc, out_payload         from the stage register
//   out_rs1_data, out_rs2_data  resolved operands
module core_id_operand_fetch #(
  parameter int PAYLOAD_W = 64,
  parameter bit FWD_EN    = 1'b1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [31:0]          in_pc,
  input  logic [4:0]           in_rs1,
  input  logic [4:0]           in_rs2,
  input  logic                 in_rs1_used,
  input  logic                 in_rs2_used,
  input  logic [PAYLOAD_W-1:0] in_payload,
  output logic [4:0]           rf_read_0_addr,
  input  logic [31:0]          rf_read_0_data,
  output logic [4:0]           rf_read_1_addr,
  input  logic [31:0]          rf_read_1_data,
  input  logic                 wb_en,
  input  logic [4:0]           wb_addr,
  input  logic [31:0]          wb_data,
  input  logic                 fwd_ex_valid,
  input  logic [4:0]           fwd_ex_rd,
  input  logic [31:0]          fwd_ex_data,
  input  logic                 fwd_ex_ready,
  input  logic                 fwd_mem_valid,
  input  logic [4:0]           fwd_mem_rd,
  input  logic [31:0]          fwd_mem_data,
  input  logic                 flush,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [31:0]          out_pc,
  output logic [PAYLOAD_W-1:0] out_payload,
  output logic [31:0]          out_rs1_data,
  output logic [31:0]          out_rs2_data
);

  typedef struct packed {
    logic                 v;
    logic [31:0]          pc;
    logic [4:0]           rs1;
    logic [4:0]           rs2;
    logic                 used1;
    logic                 used2;
    logic [PAYLOAD_W-1:0] payload;
  } stage_t;

  stage_t      s;
  logic        hit0, hit1;
  logic [31:0] wbd0, wbd1;
  logic        accept, fire, hazard;

  // Resolve one operand from the forwarding network, highest priority first.
  // rs==0 short-circuits, so rd==0 on any source can never match.
  function automatic logic [31:0] resolve(
    input logic [4:0]  rs,
    input logic [31:0] rf_data,
    input logic        hit,
    input logic [31:0] wbd,
    input logic        ex_v,
    input logic [4:0]  ex_rd,
    input logic [31:0] ex_d,
    input logic        ex_r,
    input logic        mem_v,
    input logic [4:0]  mem_rd,
    input logic [31:0] mem_d,
    input logic        w_en,
    input logic [4:0]  w_addr,
    input logic [31:0] w_data
  );
    logic [31:0] r;
    r = rf_data;
    if (rs == 5'd0)                                 r = 32'd0;
    else if (FWD_EN && ex_v && ex_rd == rs && ex_r) r = ex_d;
    else if (FWD_EN && mem_v && mem_rd == rs)       r = mem_d;
    else if (w_en && w_addr == rs)                  r = w_data;
    else if (hit)                                   r = wbd;
    return r;
  endfunction

  // An operand is blocked when EX holds an unknown result for it; without
  // forwarding any in-flight EX or MEM producer blocks it.
  function automatic logic blocked(
    input logic       used,
    input logic [4:0] rs,
    input logic       ex_v,
    input logic [4:0] ex_rd,
    input logic       ex_r,
    input logic       mem_v,
    input logic [4:0] mem_rd
  );
    logic ex_m, mem_m, b;
    ex_m  = ex_v && (ex_rd == rs);
    mem_m = mem_v && (mem_rd == rs);
    if (FWD_EN) b = ex_m && !ex_r;
    else        b = ex_m || mem_m;
    return used && (rs != 5'd0) && b;
  endfunction

  always_comb begin
    hazard = blocked(s.used1, s.rs1, fwd_ex_valid, fwd_ex_rd, fwd_ex_ready,
                     fwd_mem_valid, fwd_mem_rd)
          || blocked(s.used2, s.rs2, fwd_ex_valid, fwd_ex_rd, fwd_ex_ready,
                     fwd_mem_valid, fwd_mem_rd);
    out_valid = s.v && !hazard;
    fire      = out_valid && out_ready;
    in_ready  = !s.v || fire;
    accept    = in_valid && in_ready && !flush;
    // While stalled, keep reading the held sources so RF data stays current.
    rf_read_0_addr = in_ready ? in_rs1 : s.rs1;
    rf_read_1_addr = in_ready ? in_rs2 : s.rs2;
    out_pc       = s.pc;
    out_payload  = s.payload;
    out_rs1_data = resolve(s.rs1, rf_read_0_data, hit0, wbd0,
                           fwd_ex_valid, fwd_ex_rd, fwd_ex_data, fwd_ex_ready,
                           fwd_mem_valid, fwd_mem_rd, fwd_mem_data,
                           wb_en, wb_addr, wb_data);
    out_rs2_data = resolve(s.rs2, rf_read_1_data, hit1, wbd1,
                           fwd_ex_valid, fwd_ex_rd, fwd_ex_data, fwd_ex_ready,
                           fwd_mem_valid, fwd_mem_rd, fwd_mem_data,
                           wb_en, wb_addr, wb_data);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s <= '0;
    end else if (flush) begin
      s.v <= 1'b0;
    end else if (accept) begin
      s.v       <= 1'b1;
      s.pc      <= in_pc;
      s.rs1     <= in_rs1;
      s.rs2     <= in_rs2;
      s.used1   <= in_rs1_used;
      s.used2   <= in_rs2_used;
      s.payload <= in_payload;
    end else if (fire) begin
      s.v <= 1'b0;
    end
  end

  // The register file returns the pre-write value when it is read and written
  // on the same edge; remember such writes so the stale read is overridden.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hit0 <= 1'b0;
      hit1 <= 1'b0;
      wbd0 <= 32'd0;
      wbd1 <= 32'd0;
    end else begin
      hit0 <= !flush && wb_en && (wb_addr == rf_read_0_addr) && (wb_addr != 5'd0);
      hit1 <= !flush && wb_en && (wb_addr == rf_read_1_addr) && (wb_addr != 5'd0);
      wbd0 <= wb_data;
      wbd1 <= wb_data;
    end
  end

endmodule

// File: tb/tb_core_id_operand_fetch.sv
module tb_core_id_operand_fetch;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid, in_ready;
  logic [31:0] in_pc;
  logic [4:0]  in_rs1, in_rs2;
  logic        in_rs1_used, in_rs2_used;
  logic [63:0] in_payload;
  logic [4:0]  rf_read_0_addr, rf_read_1_addr;
  logic [31:0] rf_read_0_data, rf_read_1_data;
  logic        wb_en;
  logic [4:0]  wb_addr;
  logic [31:0] wb_data;
  logic        fwd_ex_valid, fwd_ex_ready;
  logic [4:0]  fwd_ex_rd;
  logic [31:0] fwd_ex_data;
  logic        fwd_mem_valid;
  logic [4:0]  fwd_mem_rd;
  logic [31:0] fwd_mem_data;
  logic        flush;
  logic        out_valid, out_ready;
  logic [31:0] out_pc, out_rs1_data, out_rs2_data;
  logic [63:0] out_payload;

  int checks = 0;
  int errors = 0;

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  core_id_operand_fetch #(.PAYLOAD_W(64), .FWD_EN(1'b1)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_pc(in_pc),
    .in_rs1(in_rs1), .in_rs2(in_rs2),
    .in_rs1_used(in_rs1_used), .in_rs2_used(in_rs2_used),
    .in_payload(in_payload),
    .rf_read_0_addr(rf_read_0_addr), .rf_read_0_data(rf_read_0_data),
    .rf_read_1_addr(rf_read_1_addr), .rf_read_1_data(rf_read_1_data),
    .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data),
    .fwd_ex_valid(fwd_ex_valid), .fwd_ex_rd(fwd_ex_rd),
    .fwd_ex_data(fwd_ex_data), .fwd_ex_ready(fwd_ex_ready),
    .fwd_mem_valid(fwd_mem_valid), .fwd_mem_rd(fwd_mem_rd),
    .fwd_mem_data(fwd_mem_data),
    .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc),
    .out_payload(out_payload),
    .out_rs1_data(out_rs1_data), .out_rs2_data(out_rs2_data)
  );

  // Register-file model: synchronous read returning the pre-write value.
  logic [31:0] rf [32];
  always @(posedge clk) begin
    rf_read_0_data <= rf[rf_read_0_addr];
    rf_read_1_data <= rf[rf_read_1_addr];
    if (wb_en && wb_addr != 5'd0) rf[wb_addr] <= wb_data;
  end

  // ---------------- scoreboard helpers ----------------
  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic idle();
    in_valid = 1'b0; in_pc = 32'd0; in_rs1 = 5'd0; in_rs2 = 5'd0;
    in_rs1_used = 1'b0; in_rs2_used = 1'b0; in_payload = 64'd0;
    wb_en = 1'b0; wb_addr = 5'd0; wb_data = 32'd0;
    fwd_ex_valid = 1'b0; fwd_ex_rd = 5'd0; fwd_ex_data = 32'd0; fwd_ex_ready = 1'b1;
    fwd_mem_valid = 1'b0; fwd_mem_rd = 5'd0; fwd_mem_data = 32'd0;
    flush = 1'b0; out_ready = 1'b1;
  endtask

  task automatic send(input logic [31:0] pc, input logic [4:0] r1, input logic [4:0] r2,
                      input logic u1, input logic u2);
    in_valid = 1'b1; in_pc = pc; in_rs1 = r1; in_rs2 = r2;
    in_rs1_used = u1; in_rs2_used = u2; in_payload = {~pc, pc};
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic        iv;
    logic [31:0] pc;
    logic [4:0]  r1, r2;
    logic        u1, u2;
    logic        ex_v;
    logic [4:0]  ex_rd;
    logic [31:0] ex_d;
    logic        ex_r;
    logic        mem_v;
    logic [4:0]  mem_rd;
    logic [31:0] mem_d;
    logic        ordy;
    logic        e_in_ready, e_out_valid;
    logic [31:0] e_pc, e_rs1, e_rs2;
  } vec_t;

  function automatic vec_t mk(
    input logic iv, input logic [31:0] pc, input logic [4:0] r1, input logic [4:0] r2,
    input logic u1, input logic u2,
    input logic ex_v, input logic [4:0] ex_rd, input logic [31:0] ex_d, input logic ex_r,
    input logic mem_v, input logic [4:0] mem_rd, input logic [31:0] mem_d,
    input logic ordy, input logic e_ir, input logic e_ov,
    input logic [31:0] e_pc, input logic [31:0] e_rs1, input logic [31:0] e_rs2);
    vec_t v;
    v.iv = iv; v.pc = pc; v.r1 = r1; v.r2 = r2; v.u1 = u1; v.u2 = u2;
    v.ex_v = ex_v; v.ex_rd = ex_rd; v.ex_d = ex_d; v.ex_r = ex_r;
    v.mem_v = mem_v; v.mem_rd = mem_rd; v.mem_d = mem_d; v.ordy = ordy;
    v.e_in_ready = e_ir; v.e_out_valid = e_ov; v.e_pc = e_pc;
    v.e_rs1 = e_rs1; v.e_rs2 = e_rs2;
    return v;
  endfunction

  vec_t vecs [12];

  initial begin
    // Each row: inputs applied this cycle; expectations for the outputs seen
    // in the same cycle (stage contents from earlier rows). Forwarding inputs
    // target the instruction currently held in the stage.
    //            iv  pc       r1  r2  u1 u2 exv exrd exd       exr memv mrd md        ordy ir ov pc       rs1        rs2
    vecs[0]  = mk(1, 32'h100,  5,  0, 1, 0, 0,  0, 32'h0,     1,  0,  0, 32'h0,     1,   1, 0, 32'h0,   32'h0,     32'h0);
    vecs[1]  = mk(1, 32'h104,  3,  6, 1, 1, 0,  0, 32'h0,     1,  0,  0, 32'h0,     1,   1, 1, 32'h100, 32'h11,    32'h0);
    vecs[2]  = mk(1, 32'h108,  9,  3, 1, 1, 1,  3, 32'h55,    1,  1,  3, 32'h66,    1,   1, 1, 32'h104, 32'h55,    32'h106);
    vecs[3]  = mk(1, 32'h10C, 10, 11, 1, 1, 1,  7, 32'h77,    1,  1,  3, 32'h66,    1,   1, 1, 32'h108, 32'h109,   32'h66);
    vecs[4]  = mk(1, 32'h110,  0, 12, 0, 1, 1,  0, 32'hDEAD,  1,  1, 10, 32'h3A,    1,   1, 1, 32'h10C, 32'h3A,    32'h10B);
    vecs[5]  = mk(0, 32'h0,    0,  0, 0, 0, 1,  0, 32'hDEAD,  1,  1,  0, 32'hBEEF,  1,   1, 1, 32'h110, 32'h0,     32'h10C);
    vecs[6]  = mk(1, 32'h114, 13, 14, 0, 1, 0,  0, 32'h0,     1,  0,  0, 32'h0,     0,   1, 0, 32'h0,   32'h0,     32'h0);
    vecs[7]  = mk(1, 32'h118,  1,  2, 1, 1, 1, 13, 32'h0,     0,  0,  0, 32'h0,     0,   0, 1, 32'h114, 32'h10D,   32'h10E);
    vecs[8]  = mk(1, 32'h118,  1,  2, 1, 1, 1, 14, 32'h0,     0,  0,  0, 32'h0,     1,   0, 0, 32'h0,   32'h0,     32'h0);
    vecs[9]  = mk(1, 32'h118,  1,  2, 1, 1, 1, 14, 32'h99,    1,  0,  0, 32'h0,     1,   1, 1, 32'h114, 32'h10D,   32'h99);
    vecs[10] = mk(0, 32'h0,    0,  0, 0, 0, 0,  0, 32'h0,     1,  0,  0, 32'h0,     1,   1, 1, 32'h118, 32'h101,   32'h102);
    vecs[11] = mk(0, 32'h0,    0,  0, 0, 0, 0,  0, 32'h0,     1,  0,  0, 32'h0,     1,   1, 0, 32'h0,   32'h0,     32'h0);
  end

  // ---------------- main sequence ----------------
  initial begin
    for (int i = 0; i < 32; i++) rf[i] = 32'h100 + i;
    rf[0] = 32'd0;
    rf[5] = 32'h11;
    idle();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("reset_out_valid", out_valid, 0);
    check("reset_in_ready", in_ready, 1);
    check("reset_out_pc", out_pc, 0);
    check("reset_out_payload", out_payload, 0);
    check("reset_rs1", out_rs1_data, 0);
    check("reset_rs2", out_rs2_data, 0);

    // Table-driven vectors.
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      idle();
      if (vecs[i].iv) send(vecs[i].pc, vecs[i].r1, vecs[i].r2, vecs[i].u1, vecs[i].u2);
      fwd_ex_valid = vecs[i].ex_v; fwd_ex_rd = vecs[i].ex_rd;
      fwd_ex_data = vecs[i].ex_d; fwd_ex_ready = vecs[i].ex_r;
      fwd_mem_valid = vecs[i].mem_v; fwd_mem_rd = vecs[i].mem_rd;
      fwd_mem_data = vecs[i].mem_d;
      out_ready = vecs[i].ordy;
      #1;
      check($sformatf("vec%0d_in_ready", i), in_ready, vecs[i].e_in_ready);
      check($sformatf("vec%0d_out_valid", i), out_valid, vecs[i].e_out_valid);
      if (vecs[i].e_out_valid) begin
        check($sformatf("vec%0d_pc", i), out_pc, vecs[i].e_pc);
        check($sformatf("vec%0d_payload", i), out_payload, {~vecs[i].e_pc, vecs[i].e_pc});
        check($sformatf("vec%0d_rs1", i), out_rs1_data, vecs[i].e_rs1);
        check($sformatf("vec%0d_rs2", i), out_rs2_data, vecs[i].e_rs2);
      end
    end

    // Write-back on the same edge as accept: RF returns stale data, latch wins.
    @(negedge clk); idle();
    send(32'h200, 5'd7, 5'd0, 1'b1, 1'b0);
    wb_en = 1'b1; wb_addr = 5'd7; wb_data = 32'hAB;
    #1 check("wbsame_in_ready", in_ready, 1);
    @(negedge clk); idle();
    #1;
    check("wbsame_out_valid", out_valid, 1);
    check("wbsame_pc", out_pc, 32'h200);
    check("wbsame_rs1", out_rs1_data, 32'hAB);
    @(negedge clk); idle();
    #1 check("wbsame_drained", out_valid, 0);

    // Downstream stall of 3 cycles with a write-back in the middle.
    @(negedge clk); idle();
    send(32'h300, 5'd8, 5'd0, 1'b1, 1'b0); out_ready = 1'b0;
    @(negedge clk); idle(); out_ready = 1'b0;
    #1;
    check("stall1_out_valid", out_valid, 1);
    check("stall1_in_ready", in_ready, 0);
    check("stall1_rs1", out_rs1_data, 32'h108);
    check("stall1_rf_addr", rf_read_0_addr, 5'd8);
    @(negedge clk); idle(); out_ready = 1'b0;
    wb_en = 1'b1; wb_addr = 5'd8; wb_data = 32'h42;
    #1 check("stall2_rs1_wb_now", out_rs1_data, 32'h42);
    @(negedge clk); idle(); out_ready = 1'b0;
    #1;
    check("stall3_rs1_latched", out_rs1_data, 32'h42);
    check("stall3_out_valid", out_valid, 1);
    @(negedge clk); idle();
    #1;
    check("stall_fire_rs1", out_rs1_data, 32'h42);
    check("stall_fire_valid", out_valid, 1);
    check("stall_fire_pc", out_pc, 32'h300);
    @(negedge clk); idle();
    #1 check("stall_fired_once", out_valid, 0);

    // Load-use stall: out_ready=1 but operand unknown, hold rf address.
    @(negedge clk); idle();
    send(32'h380, 5'd0, 5'd4, 1'b0, 1'b1);
    for (int k = 0; k < 2; k++) begin
      @(negedge clk); idle();
      send(32'h384, 5'd1, 5'd1, 1'b0, 1'b0);
      fwd_ex_valid = 1'b1; fwd_ex_rd = 5'd4; fwd_ex_ready = 1'b0;
      #1;
      check($sformatf("loaduse%0d_out_valid", k), out_valid, 0);
      check($sformatf("loaduse%0d_in_ready", k), in_ready, 0);
      check($sformatf("loaduse%0d_rf_addr", k), rf_read_1_addr, 5'd4);
    end
    @(negedge clk); idle();
    fwd_ex_valid = 1'b1; fwd_ex_rd = 5'd4; fwd_ex_ready = 1'b1; fwd_ex_data = 32'h99;
    #1;
    check("loaduse_res_valid", out_valid, 1);
    check("loaduse_res_rs2", out_rs2_data, 32'h99);
    check("loaduse_res_pc", out_pc, 32'h380);
    @(negedge clk); idle();
    #1 check("loaduse_drained", out_valid, 0);

    // Flush with a held instruction and a new input in the same cycle.
    @(negedge clk); idle();
    send(32'h400, 5'd1, 5'd2, 1'b1, 1'b1); out_ready = 1'b0;
    @(negedge clk); idle();
    send(32'h404, 5'd3, 5'd4, 1'b1, 1'b1); flush = 1'b1;
    #1 check("preflush_out_valid", out_valid, 1);
    @(negedge clk); idle();
    #1;
    check("flush_out_valid", out_valid, 0);
    check("flush_in_ready", in_ready, 1);
    @(negedge clk); idle();
    #1 check("flush_no_issue", out_valid, 0);

    // Asynchronous reset in the middle of a load-use stall.
    @(negedge clk); idle();
    send(32'h500, 5'd0, 5'd4, 1'b0, 1'b1);
    @(negedge clk); idle();
    fwd_ex_valid = 1'b1; fwd_ex_rd = 5'd4; fwd_ex_ready = 1'b0;
    #1;
    check("prerst_out_valid", out_valid, 0);
    check("prerst_in_ready", in_ready, 0);
    #2 rst_n = 1'b0;
    #1;
    check("rst_async_out_valid", out_valid, 0);
    check("rst_async_in_ready", in_ready, 1);
    check("rst_async_out_pc", out_pc, 0);
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk);
    #1 check("rst_no_survivor", out_valid, 0);

    @(negedge clk); idle();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
